// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-capturing interrupt arbiter feeding the CSR file.
// Latches rising edges on the source lines as pending. Picks the
// highest-priority enabled pending source and delivers it as a one-cycle
// e_intr_o pulse. Further interrupts are held off until mret.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no delivery in progress, arbitrating every cycle
// FIRE    | e_intr_o asserted for this single cycle, irq_id_o valid
// SERVICE | handler running, waiting for mret to retire
module intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               mstatus_mie_i,
  input  logic               pipe_ready_i,
  input  logic               is_mret_i,
  input  logic               cfg_we_i,
  input  logic [7:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic               e_intr_o,
  output logic [3:0]         irq_id_o,
  output logic               busy_o
);

  localparam int ID_W = 4;

  localparam logic [7:0] ADDR_EN    = 8'h40;
  localparam logic [7:0] ADDR_THR   = 8'h44;
  localparam logic [7:0] ADDR_PEND  = 8'h48;
  localparam logic [7:0] ADDR_CLAIM = 8'h4C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [PRIO_W-1:0]  thr_q, thr_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] cand;
  logic               cand_valid;
  logic [ID_W-1:0]    win_idx;
  logic [PRIO_W-1:0]  win_prio;
  logic               claim;

  logic [NUM_SRC-1:0] wr_prio;
  logic               wr_en;
  logic               wr_thr;
  logic               wr_pend;

  // Upper write-data bits have no destination for narrow registers.
  logic unused_wdata;
  assign unused_wdata = ^cfg_wdata_i;

  // A source is a new event only on a 0->1 transition of its sampled line.
  assign prev_d = irq_src_i;
  assign rise   = irq_src_i & ~prev_q;

  // Decode config write strobes per register.
  always_comb begin
    wr_prio = '0;
    wr_en   = 1'b0;
    wr_thr  = 1'b0;
    wr_pend = 1'b0;
    if (cfg_we_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_addr_i == 8'(4 * i)) begin
          wr_prio[i] = 1'b1;
        end
      end
      wr_en   = (cfg_addr_i == ADDR_EN);
      wr_thr  = (cfg_addr_i == ADDR_THR);
      wr_pend = (cfg_addr_i == ADDR_PEND);
    end
  end

  // Next values of the software-owned config registers.
  always_comb begin
    prio_d = prio_q;
    en_d   = en_q;
    thr_d  = thr_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr_prio[i]) begin
        prio_d[i] = cfg_wdata_i[PRIO_W-1:0];
      end
    end
    if (wr_en) begin
      en_d = cfg_wdata_i[NUM_SRC-1:0];
    end
    if (wr_thr) begin
      thr_d = cfg_wdata_i[PRIO_W-1:0];
    end
  end

  // Arbitration: strict greater-than keeps the lowest index on a tie.
  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    win_idx    = '0;
    win_prio   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand[i] = pend_q[i] & en_q[i] & (prio_q[i] > thr_q);
      if (cand[i] && (prio_q[i] > win_prio)) begin
        win_prio   = prio_q[i];
        win_idx    = ID_W'(i);
        cand_valid = 1'b1;
      end
    end
  end

  // Delivery FSM next state; claim marks the IDLE->FIRE transition.
  always_comb begin
    state_d = state_q;
    claim   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_valid && mstatus_mie_i && pipe_ready_i) begin
          claim   = 1'b1;
          state_d = FIRE;
        end
      end
      FIRE: begin
        state_d = SERVICE;
      end
      SERVICE: begin
        if (is_mret_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending update: W1C and claim clear first, so a same-cycle rising edge wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_pend) begin
      pend_d = pend_d & ~cfg_wdata_i[NUM_SRC-1:0];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (claim && (win_idx == ID_W'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
    pend_d = pend_d | rise;
  end

  // In-service id: captured on claim, dropped as the handler's mret retires.
  always_comb begin
    id_d = id_q;
    if (claim) begin
      id_d = win_idx;
    end else if ((state_q == SERVICE) && is_mret_i) begin
      id_d = '0;
    end
  end

  // Config read mux; unmapped addresses read as zero.
  always_comb begin
    cfg_rdata_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cfg_addr_i == 8'(4 * i)) begin
        cfg_rdata_o = 32'(prio_q[i]);
      end
    end
    case (cfg_addr_i)
      ADDR_EN:    cfg_rdata_o = 32'(en_q);
      ADDR_THR:   cfg_rdata_o = 32'(thr_q);
      ADDR_PEND:  cfg_rdata_o = 32'(pend_q);
      ADDR_CLAIM: cfg_rdata_o = busy_o ? 32'(id_q) : 32'd0;
      default:    ;
    endcase
  end

  // All state registers; reset clears configuration as well as delivery state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      en_q    <= '0;
      thr_q   <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      id_q    <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      id_q    <= id_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_q[i] <= prio_d[i];
      end
    end
  end

  assign e_intr_o = (state_q == FIRE);
  assign busy_o   = (state_q != IDLE);
  assign irq_id_o = id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Testbench for intr_ctrl: directed scenarios feed a scoreboard of expected
// interrupt deliveries and register/status values; a negedge monitor pops
// and compares them.
`timescale 1ns/1ps
module tb_intr_ctrl;

  localparam int NUM_SRC = 8;
  localparam int PRIO_W  = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_SRC-1:0] irq_src = '0;
  logic               mie = 1'b0;
  logic               ready = 1'b0;
  logic               is_mret = 1'b0;
  logic               cfg_we = 1'b0;
  logic [7:0]         cfg_addr = '0;
  logic [31:0]        cfg_wdata = '0;
  logic [31:0]        cfg_rdata;
  logic               e_intr;
  logic [3:0]         irq_id;
  logic               busy;

  intr_ctrl #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .irq_src_i     (irq_src),
    .mstatus_mie_i (mie),
    .pipe_ready_i  (ready),
    .is_mret_i     (is_mret),
    .cfg_we_i      (cfg_we),
    .cfg_addr_i    (cfg_addr),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_rdata_o   (cfg_rdata),
    .e_intr_o      (e_intr),
    .irq_id_o      (irq_id),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Count rising edges; at a negedge cyc equals the number of edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected pulses (id, cycle) and expected values of samples.
  logic [3:0]  exp_id_q  [$];
  int          exp_cyc_q [$];
  string       nm_q      [$];
  logic [31:0] act_q     [$];
  logic [31:0] expv_q    [$];

  int checks = 0;
  int errors = 0;

  // Monitor: compare every pulse against the head of the expectation queue
  // and drain the sampled-value comparisons.
  always @(negedge clk) begin : monitor
    logic [3:0]  eid;
    int          ec;
    string       nm;
    logic [31:0] a;
    logic [31:0] e;
    if (e_intr === 1'b1) begin
      checks++;
      if (exp_id_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got id=%0d at cycle %0d, no pulse required", irq_id, cyc);
      end else begin
        eid = exp_id_q.pop_front();
        ec  = exp_cyc_q.pop_front();
        if (irq_id !== eid || cyc != ec || busy !== 1'b1) begin
          errors++;
          $display("FAIL pulse: got id=%0d cycle=%0d busy=%0b, required id=%0d cycle=%0d busy=1",
                   irq_id, cyc, busy, eid, ec);
        end
      end
    end
    while (nm_q.size() > 0) begin
      nm = nm_q.pop_front();
      a  = act_q.pop_front();
      e  = expv_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got 0x%0h, required 0x%0h", nm, a, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nm_q.push_back(nm);
    act_q.push_back(a);
    expv_q.push_back(e);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] e, input string nm);
    cfg_addr = addr;
    #1;
    chk(nm, cfg_rdata, e);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic expect_pulse(input logic [3:0] id, input int c);
    exp_id_q.push_back(id);
    exp_cyc_q.push_back(c);
  endtask

  task automatic mret();
    is_mret = 1'b1;
    @(negedge clk);
    is_mret = 1'b0;
  endtask

  task automatic status(input string nm, input logic b, input logic [3:0] id);
    chk({nm, "_busy"}, 32'(b), 32'(busy));
    chk({nm, "_id"},   32'(id), 32'(irq_id));
  endtask

  int c;
  int d;

  initial begin
    // Reset values
    tick(3);
    rst_n = 1'b1;
    chk("rst_busy",  32'(busy),   32'd0);
    chk("rst_eintr", 32'(e_intr), 32'd0);
    chk("rst_id",    32'(irq_id), 32'd0);
    rd(8'h48, 32'h0, "rst_pend");
    rd(8'h44, 32'h0, "rst_thr");
    tick(1);

    // Single source
    wr(8'h08, 32'd3);
    wr(8'h40, 32'h04);
    mie   = 1'b1;
    ready = 1'b1;
    c = cyc;
    irq_src[2] = 1'b1;
    expect_pulse(4'd2, c + 2);
    tick(1);
    rd(8'h48, 32'h04, "t1_pend_set");
    tick(1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_id",   32'(irq_id), 32'd2);
    rd(8'h48, 32'h00, "t1_pend_clr");
    rd(8'h4C, 32'h02, "t1_claim");
    tick(5);
    chk("t1_busy_hold", 32'(busy), 32'd1);
    mret();
    chk("t1_busy_after_mret", 32'(busy), 32'd0);
    chk("t1_id_after_mret",   32'(irq_id), 32'd0);
    rd(8'h4C, 32'h00, "t1_claim_idle");
    irq_src = '0;
    tick(2);

    // Priority and tie
    wr(8'h04, 32'd2);
    wr(8'h14, 32'd5);
    wr(8'h18, 32'd5);
    wr(8'h40, 32'h66);
    c = cyc;
    irq_src = 8'h62;
    expect_pulse(4'd5, c + 2);
    tick(4);
    d = cyc;
    expect_pulse(4'd6, d + 2);
    mret();
    tick(3);
    d = cyc;
    expect_pulse(4'd1, d + 2);
    mret();
    tick(3);
    mret();
    tick(3);
    chk("t2_busy_done", 32'(busy), 32'd0);
    rd(8'h48, 32'h00, "t2_pend_done");
    irq_src = '0;
    tick(1);

    // Threshold and mask
    wr(8'h0C, 32'd2);
    wr(8'h44, 32'd2);
    wr(8'h40, 32'h6E);
    irq_src[3] = 1'b1;
    tick(5);
    rd(8'h48, 32'h08, "t3_pend_below_thr");
    chk("t3_busy_below_thr", 32'(busy), 32'd0);
    d = cyc;
    expect_pulse(4'd3, d + 2);
    wr(8'h44, 32'd1);
    tick(1);
    status("t3_deliver", 1'b1, 4'd3);
    irq_src = '0;
    tick(2);
    mret();
    wr(8'h10, 32'd7);
    irq_src[4] = 1'b1;
    tick(5);
    rd(8'h48, 32'h10, "t3_pend_disabled");
    chk("t3_busy_disabled", 32'(busy), 32'd0);
    wr(8'h48, 32'h10);
    rd(8'h48, 32'h00, "t3_w1c");
    irq_src = '0;
    tick(1);

    // Deferral by MIE, then by pipe_ready
    wr(8'h00, 32'd4);
    wr(8'h40, 32'h6F);
    mie = 1'b0;
    irq_src[0] = 1'b1;
    tick(50);
    rd(8'h48, 32'h01, "t4_pend_held");
    chk("t4_busy_held", 32'(busy), 32'd0);
    c = cyc;
    mie = 1'b1;
    expect_pulse(4'd0, c + 1);
    tick(1);
    chk("t4_busy_mie", 32'(busy), 32'd1);
    tick(2);
    mret();
    irq_src = '0;
    tick(1);
    c = cyc;
    irq_src[0] = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(5);
    ready = 1'b1;
    expect_pulse(4'd0, c + 7);
    tick(1);
    chk("t4_busy_ready", 32'(busy), 32'd1);
    tick(2);
    mret();
    irq_src = '0;
    tick(1);

    // Collision: re-rise on the winner's line in its claim cycle
    mie = 1'b0;
    c = cyc;
    irq_src[2] = 1'b1;
    tick(1);
    irq_src[2] = 1'b0;
    tick(1);
    irq_src[2] = 1'b1;
    mie = 1'b1;
    expect_pulse(4'd2, c + 3);
    tick(1);
    rd(8'h48, 32'h04, "t5_pend_kept");
    chk("t5_id", 32'(irq_id), 32'd2);
    tick(2);
    d = cyc;
    expect_pulse(4'd2, d + 2);
    mret();
    tick(3);
    mret();
    tick(1);
    rd(8'h48, 32'h00, "t5_pend_done");
    irq_src = '0;
    tick(1);

    // W1C clears without delivery; W1C losing to a same-cycle set
    mie = 1'b0;
    irq_src[2] = 1'b1;
    tick(1);
    rd(8'h48, 32'h04, "t5_pend_before_w1c");
    wr(8'h48, 32'h04);
    rd(8'h48, 32'h00, "t5_w1c_clear");
    mie = 1'b1;
    tick(10);
    chk("t5_busy_after_w1c", 32'(busy), 32'd0);
    mie = 1'b0;
    irq_src = '0;
    tick(1);
    irq_src[2] = 1'b1;
    wr(8'h48, 32'h04);
    rd(8'h48, 32'h04, "t5_w1c_vs_set");
    wr(8'h48, 32'h04);
    rd(8'h48, 32'h00, "t5_w1c_final");
    irq_src = '0;
    mie = 1'b1;
    tick(1);

    // Unmapped address and config readback
    wr(8'h50, 32'hFF);
    rd(8'h50, 32'h0, "unmapped_read");
    rd(8'h44, 32'h1, "thr_read");
    tick(1);

    // Reset mid-service
    wr(8'h1C, 32'd6);
    wr(8'h40, 32'hEF);
    c = cyc;
    irq_src = 8'h82;
    expect_pulse(4'd7, c + 2);
    tick(4);
    status("t6_service", 1'b1, 4'd7);
    rd(8'h48, 32'h02, "t6_pend_before");
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(busy),   32'd0);
    chk("t6_rst_id",    32'(irq_id), 32'd0);
    chk("t6_rst_eintr", 32'(e_intr), 32'd0);
    rd(8'h48, 32'h0, "t6_rst_pend");
    irq_src = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      rd(8'(4 * i), 32'h0, "t6_prio_after_rst");
    end
    rd(8'h40, 32'h0, "t6_en_after_rst");
    rd(8'h44, 32'h0, "t6_thr_after_rst");
    rd(8'h48, 32'h0, "t6_pend_after_rst");
    rd(8'h4C, 32'h0, "t6_claim_after_rst");
    tick(3);

    chk("pulses_outstanding", 32'(exp_id_q.size()), 32'd0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
